handshake_sink: RTL and testbench



---
 rtl/handshake_pkg.sv | 14 +
 rtl/sync_fifo.sv | 70 +++++++
 rtl/handshake_sink.sv | 79 +++++++
 tb/tb_handshake_sink.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// Shared types and default sizes for the async-to-clocked handshake stages.
package handshake_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } sink_state_t;

    // Defaults shared with the neighbouring incrementer stage
    localparam int DEF_WIDTH       = 8;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with an occupancy counter.
// The head word is registered storage, so nothing falls through: a word
// pushed on one edge first appears after that edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]               level_q, level_d;
    logic                        push_ok, pop_ok;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Next storage, pointer and occupancy values; DEPTH is a power of two so pointers wrap naturally
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // State registers; storage clears too so the head reads 0 until the first push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/handshake_sink.sv
// Clocked consumer of a four-phase req/ack bundled-data channel.
// req_in is synchronized, each request is acknowledged once, and the
// captured word is queued for a valid/ready consumer.
module handshake_sink
    import handshake_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_in,
    output logic                         ack_out,
    input  logic [WIDTH-1:0]             data_in,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   req_s;
    sink_state_t            state_q, state_d;
    logic                   push, pop, empty, full;

    // Shift req_in through the synchronizer chain; only the last stage is used
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], req_in};
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    // Synchronizer and FSM state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= IDLE;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
        end
    end

    // Next state: acknowledge a request only when there is room, release when req drops
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_s && !full) state_d = ACK;
            ACK:     if (!req_s)         state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: ack is the state flop itself; push fires on the IDLE->ACK edge only
    always_comb begin
        ack_out = (state_q == ACK);
        push    = (state_q == IDLE) && req_s && !full;
        pop     = out_valid && out_ready;
    end

    assign out_valid = !empty;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (data_in),
        .pop       (pop),
        .rd_data   (out_data),
        .empty     (empty),
        .full      (full),
        .level     (level)
    );

endmodule

// File: tb/tb_handshake_sink.sv
// Bench for handshake_sink: a constant vector table, directed corner-case
// sequences, and randomized traffic checked every cycle against a queue model.
module tb_handshake_sink;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_in;
    logic         ack_out;
    logic [W-1:0] data_in;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   level;

    int total = 0;
    int bad   = 0;

    handshake_sink #(.WIDTH(W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .ack_out   (ack_out),
        .data_in   (data_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level)
    );

    always #5 clk = ~clk;

    // Reference model: word queue, acked flag, req delay line, "anything pushed yet"
    logic [W-1:0] mq[$];
    bit           m_ack;
    bit           m_sync[$];
    bit           m_pushed;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ack    = 1'b0;
        m_pushed = 1'b0;
        m_sync.delete();
        for (int i = 0; i < SYNC; i++) m_sync.push_back(1'b0);
    endtask

    // One clock: model applies the handshake/FIFO rules, then DUT is compared 1ns after the edge
    task automatic tick();
        bit           r, rd, rs, do_push, do_pop;
        logic [W-1:0] d;
        r  = req_in;
        rd = out_ready;
        d  = data_in;
        @(posedge clk);
        rs      = m_sync[0];
        do_push = !m_ack && rs && (mq.size() < DEPTH);
        do_pop  = (mq.size() > 0) && rd;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            mq.push_back(d);
            m_pushed = 1'b1;
        end
        if (do_push)           m_ack = 1'b1;
        else if (m_ack && !rs) m_ack = 1'b0;
        void'(m_sync.pop_front());
        m_sync.push_back(r);
        #1;
        chk("m_ack",   {31'd0, ack_out},   {31'd0, m_ack});
        chk("m_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
        chk("m_level", {29'd0, level},     mq.size());
        if (mq.size() > 0)  chk("m_data",  {24'd0, out_data}, {24'd0, mq[0]});
        else if (!m_pushed) chk("m_data0", {24'd0, out_data}, 32'd0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Full four-phase transfer when not full; optionally pop on the push edge
    task automatic hs(input logic [W-1:0] d, input bit rdy_on_push);
        data_in = d;
        req_in  = 1'b1;
        ticks(SYNC);
        out_ready = rdy_on_push;
        tick();
        out_ready = 1'b0;
        chk("hs_ack_rise", {31'd0, ack_out}, 32'd1);
        req_in = 1'b0;
        ticks(SYNC);
        chk("hs_ack_hold", {31'd0, ack_out}, 32'd1);
        tick();
        chk("hs_ack_fall", {31'd0, ack_out}, 32'd0);
    endtask

    task automatic drain_expect(input logic [W-1:0] first, input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            chk(nm, {24'd0, out_data}, {24'd0, first + W'(i)});
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        chk({nm, "_empty"}, {29'd0, level}, 32'd0);
    endtask

    typedef struct {
        bit           req;
        logic [W-1:0] data;
        bit           rdy;
        bit           e_ack;
        bit           e_valid;
        bit           chk_data;
        logic [W-1:0] e_data;
        int           e_level;
    } vec_t;

    vec_t vt[$];
    logic [W-1:0] exp_order[4];
    int           ack_cnt;

    initial begin
        rst = 1'b1; req_in = 1'b0; data_in = '0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ack",   {31'd0, ack_out},   32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_level", {29'd0, level},     32'd0);
        chk("rst_data",  {24'd0, out_data},  32'd0);

        // Single transfer: ack rises 3 edges after req, falls 3 edges after req drops
        vt.push_back('{1, 8'h2A, 0, 0, 0, 1, 8'h00, 0});
        vt.push_back('{1, 8'h2A, 0, 0, 0, 1, 8'h00, 0});
        vt.push_back('{1, 8'h2A, 0, 1, 1, 1, 8'h2A, 1});
        vt.push_back('{0, 8'h2A, 0, 1, 1, 1, 8'h2A, 1});
        vt.push_back('{0, 8'h2A, 0, 1, 1, 1, 8'h2A, 1});
        vt.push_back('{0, 8'h2A, 0, 0, 1, 1, 8'h2A, 1});
        vt.push_back('{0, 8'h33, 0, 0, 1, 1, 8'h2A, 1});
        vt.push_back('{0, 8'h33, 1, 0, 0, 0, 8'h00, 0});
        vt.push_back('{0, 8'h33, 1, 0, 0, 0, 8'h00, 0});
        for (int i = 0; i < vt.size(); i++) begin
            req_in = vt[i].req; data_in = vt[i].data; out_ready = vt[i].rdy;
            tick();
            chk($sformatf("vec%0d_ack", i),   {31'd0, ack_out},   {31'd0, vt[i].e_ack});
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vt[i].e_valid});
            chk($sformatf("vec%0d_level", i), {29'd0, level},     vt[i].e_level);
            if (vt[i].chk_data)
                chk($sformatf("vec%0d_data", i), {24'd0, out_data}, {24'd0, vt[i].e_data});
        end
        out_ready = 1'b0;

        // Fill to full, 5th request held off until a pop frees a slot
        for (int i = 1; i <= 4; i++) hs(W'(i), 1'b0);
        chk("full_level", {29'd0, level}, 32'd4);
        data_in = 8'h05; req_in = 1'b1;
        ticks(5);
        chk("full_noack", {31'd0, ack_out}, 32'd0);
        chk("full_level_hold", {29'd0, level}, 32'd4);
        chk("full_head", {24'd0, out_data}, 32'h01);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pop_edge_level", {29'd0, level}, 32'd3);
        chk("pop_edge_noack", {31'd0, ack_out}, 32'd0);
        tick();
        chk("late_push_ack", {31'd0, ack_out}, 32'd1);
        chk("late_push_level", {29'd0, level}, 32'd4);
        req_in = 1'b0;
        ticks(SYNC + 1);
        chk("late_ack_fall", {31'd0, ack_out}, 32'd0);
        drain_expect(8'h02, 4, "drain_order");

        // Long-held request: a single push only
        data_in = 8'h77; req_in = 1'b1; ack_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack_out) ack_cnt++;
        end
        chk("held_level", {29'd0, level}, 32'd1);
        chk("held_ack_cycles", ack_cnt, 32'd18);
        req_in = 1'b0;
        ticks(SYNC + 1);
        drain_expect(8'h77, 1, "held_drain");

        // Simultaneous push/pop at level 2 across pointer wrap
        hs(8'h10, 1'b0);
        hs(8'h11, 1'b0);
        for (int i = 2; i < 10; i++) begin
            chk("pp_head", {24'd0, out_data}, {24'd0, 8'h10 + W'(i - 2)});
            hs(8'h10 + W'(i), 1'b1);
            chk("pp_level", {29'd0, level}, 32'd2);
        end
        drain_expect(8'h18, 2, "pp_drain");

        // Asynchronous reset in the middle of ACK
        data_in = 8'h5A; req_in = 1'b1;
        ticks(SYNC + 1);
        chk("ar_pre_ack", {31'd0, ack_out}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_ack",   {31'd0, ack_out},   32'd0);
        chk("ar_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_level", {29'd0, level},     32'd0);
        model_reset();
        #1 rst = 1'b0;
        data_in = 8'h5B;
        ticks(SYNC + 1);
        chk("ar_new_ack",   {31'd0, ack_out},  32'd1);
        chk("ar_new_data",  {24'd0, out_data}, 32'h5B);
        ticks(6);
        chk("ar_one_push",  {29'd0, level},    32'd1);
        req_in = 1'b0;
        ticks(SYNC + 1);
        drain_expect(8'h5B, 1, "ar_drain");

        // Randomized traffic against the model (protocol not enforced, model tracks any pattern)
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) req_in = ~req_in;
            if (!req_in) data_in = W'($urandom);
            out_ready = ($urandom_range(2) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
